// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// and buffers returned words so IF/ID stalls and memory latency never drop one.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] BUBBLE   = 32'hFC000000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
   state_t state, state_nxt;

   logic [31:0]   fpc, fpc_nxt, fpc_inc, req_addr;
   logic [CW-1:0] count, cnt_left;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   fifo_word [DEPTH];
   logic [31:0]   fifo_addr [DEPTH];
   logic          pop, push, hold_addr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign fpc_inc  = fpc + 32'd4;
   assign pop      = !stall_i && !redirect_i && (count != '0);
   assign push     = (state == WAIT) && imem_ack_i && !redirect_i;
   assign cnt_left = count - CW'(pop);

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;

   // A new request is only launched when a FIFO slot is guaranteed for its word.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (!redirect_i && cnt_left < CW'(DEPTH)) state_nxt = WAIT;
         WAIT:
            if (imem_ack_i) begin
               if (redirect_i || !(cnt_left < CW'(DEPTH - 1))) state_nxt = IDLE;
            end else if (redirect_i) begin
               state_nxt = DISCARD;
            end
         DISCARD:
            if (imem_ack_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req_o = (state != IDLE);
   end

   always_comb begin
      fpc_nxt = fpc;
      if (redirect_i) fpc_nxt = redirect_addr_i;
      else if (push)  fpc_nxt = fpc_inc;
   end

   // While a flushed request is still outstanding, fpc holds the restart target
   // and the bus address must stay on the old request.
   assign hold_addr = !imem_ack_i && ((state == DISCARD) || (state == WAIT && redirect_i));

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         fpc      <= RESET_PC;
         req_addr <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         fpc <= fpc_nxt;
         if (!hold_addr) req_addr <= fpc_nxt;
         if (redirect_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         end
      end

   always_ff @(posedge clk_i)
      if (push) begin
         fifo_word[wr_ptr] <= imem_data_i;
         fifo_addr[wr_ptr] <= fpc_inc;
      end

   assign imem_addr_o = req_addr;

   always_comb begin
      if (count != '0) begin
         inst_o       = fifo_word[rd_ptr];
         inst_addr_o  = fifo_addr[rd_ptr];
         inst_valid_o = 1'b1;
      end else begin
         inst_o       = BUBBLE;
         inst_addr_o  = BUBBLE;
         inst_valid_o = 1'b0;
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: latency-configurable memory model plus a scoreboard of
// expected {addr+4, word} entries, consumed whenever IF/ID would take one.
module tb_if_fetch;
   localparam logic [31:0] RESET_PC = 32'h00000000;
   localparam logic [31:0] BUBBLE   = 32'hFC000000;
   localparam int          DEPTH    = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i, redirect_i, imem_ack_i;
   logic [31:0] redirect_addr_i, imem_data_i;
   logic        imem_req_o, inst_valid_o;
   logic [31:0] imem_addr_o, inst_o, inst_addr_o;

   if_fetch #(.RESET_PC(RESET_PC), .BUBBLE(BUBBLE), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_addr_i(redirect_addr_i), .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_cmp = 0, n_bad = 0;
   int          lat = 1, lat_cnt = 0;
   logic        discard = 1'b0;
   logic [31:0] disc_addr = '0, exp_fetch = RESET_PC;
   logic [63:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      lat_cnt   = 0;
      discard   = 1'b0;
      exp_fetch = RESET_PC;
   endtask

   // Called at a negedge: check outputs, decide this cycle's inputs, step one edge.
   task automatic cyc(input logic st, input logic rd, input logic [31:0] ra);
      logic ack;
      chk("valid", 32'(inst_valid_o), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
         chk("inst", inst_o, sb[0][31:0]);
         chk("inst_addr", inst_addr_o, sb[0][63:32]);
      end else begin
         chk("bubble_inst", inst_o, BUBBLE);
         chk("bubble_addr", inst_addr_o, BUBBLE);
      end
      if (sb.size() == DEPTH) chk("full_no_req", 32'(imem_req_o), 32'd0);
      if (sb.size() > 0 && !st && !rd) void'(sb.pop_front());
      ack = 1'b0;
      if (imem_req_o) begin
         lat_cnt++;
         if (lat_cnt >= lat) begin
            ack     = 1'b1;
            lat_cnt = 0;
         end
      end
      if (ack) begin
         if (discard) begin
            chk("discard_addr", imem_addr_o, disc_addr);
            discard = 1'b0;
         end else begin
            chk("req_addr", imem_addr_o, exp_fetch);
            if (!rd) begin
               sb.push_back({exp_fetch + 32'd4, exp_fetch | 32'h1000});
               exp_fetch = exp_fetch + 32'd4;
            end
         end
      end
      if (rd) begin
         sb.delete();
         if (imem_req_o && !ack && !discard) begin
            discard   = 1'b1;
            disc_addr = exp_fetch;
         end
         exp_fetch = ra;
      end
      stall_i         = st;
      redirect_i      = rd;
      redirect_addr_i = ra;
      imem_ack_i      = ack;
      imem_data_i     = ack ? (imem_addr_o | 32'h1000) : 32'hDEADBEEF;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic found;
      rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0;
      redirect_addr_i = '0; imem_data_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_inst", inst_o, BUBBLE);
      chk("rst_inst_addr", inst_addr_o, BUBBLE);
      chk("rst_valid", 32'(inst_valid_o), 32'd0);
      rst_i = 1'b0;

      // streaming, ack every cycle
      lat = 1;
      cyc(1'b0, 1'b0, 32'h0);
      chk("req_cycle1", 32'(imem_req_o), 32'd1);
      run(8);

      // stall during streaming
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);
      run(6);

      // slow memory: bubbles between deliveries
      lat = 3;
      run(12);

      // redirect while a request is outstanding and unacked
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_o && lat_cnt == 0 && !discard) found = 1'b1;
         else cyc(1'b0, 1'b0, 32'h0);
      end
      chk("to_redirect40", 32'(found), 32'd1);
      cyc(1'b0, 1'b1, 32'h40);
      run(14);

      // redirect in the same cycle as an ack with one entry buffered
      lat = 1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_o && sb.size() == 1) found = 1'b1;
         else cyc(1'b0, 1'b0, 32'h0);
      end
      chk("to_redirect80", 32'(found), 32'd1);
      cyc(1'b0, 1'b1, 32'h80);
      chk("next_req_80", imem_addr_o, 32'h80);
      run(6);

      // address wrap at the top of the space
      cyc(1'b0, 1'b1, 32'hFFFFFFF8);
      run(6);

      // asynchronous reset while waiting on a request at 0x20
      lat = 3;
      cyc(1'b0, 1'b1, 32'h20);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_o && !discard && imem_addr_o == 32'h20 && lat_cnt < lat - 1) found = 1'b1;
         else cyc(1'b0, 1'b0, 32'h0);
      end
      chk("to_wait20", 32'(found), 32'd1);
      stall_i = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_req", 32'(imem_req_o), 32'd0);
      chk("async_rst_addr", imem_addr_o, RESET_PC);
      chk("async_rst_valid", 32'(inst_valid_o), 32'd0);
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      run(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the IF/ID pipeline register. It owns the fetch PC and runs a one-outstanding req/ack handshake to instruction memory. Returned words are buffered in a small FIFO so that hazard stalls and variable memory latency do not lose instructions. When it has nothing to deliver, it presents the pipeline bubble word (opcode 6'b111111) on both instruction and address outputs.

## Interface
- RESET_PC, 32'h00000000, fetch address after reset
- BUBBLE, 32'hFC000000, word driven on inst_o/inst_addr_o when no instruction is available
- DEPTH, 2, fetch FIFO entries (≥2)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hazard stall; IF/ID will not take an instruction this cycle
- redirect_i  in  1  taken branch/jump; flush fetch and restart at redirect_addr_i
- redirect_addr_i  in  32  new fetch address, word aligned
- imem_req_o  out  1  memory request
- imem_addr_o  out  32  request address
- imem_ack_i  in  1  memory returns imem_data_i for the current request this cycle
- imem_data_i  in  32  instruction word
- inst_o  out  32  instruction to IF/ID
- inst_addr_o  out  32  fetch address + 4 of inst_o
- inst_valid_o  out  1  inst_o holds a real instruction

## Operation
- Registers:
  - fpc: next address to request.
  - FSM: IDLE, WAIT, DISCARD.
  - FIFO of {addr+4, word} with count 0..DEPTH.
- imem_req_o = (state != IDLE). imem_addr_o = fpc, registered.
- The request is held with a constant address until ack. It is never withdrawn except by reset.
- pop = !stall_i && !redirect_i && count>0. push = ack in WAIT && !redirect_i.
- IDLE:
  - redirect_i: fpc←redirect_addr_i, FIFO cleared, stay IDLE.
  - Else if count−pop < DEPTH: →WAIT.
- WAIT, no ack:
  - redirect_i: FIFO cleared, fpc←redirect_addr_i, →DISCARD.
  - Else stay WAIT.
- WAIT, ack:
  - redirect_i: word dropped, FIFO cleared, fpc←redirect_addr_i, →IDLE.
  - Else push {fpc+4, imem_data_i}, fpc←fpc+4.
  - Then stay WAIT if count−pop+1 < DEPTH, else →IDLE.
- DISCARD:
  - Hold req/address until ack.
  - On ack, drop the word and →IDLE.
  - Further redirect_i in DISCARD only updates the pending restart address (held separately from imem_addr_o) and clears the FIFO.
- Outputs, driven from the FIFO head combinationally:
  - count>0: inst_o = head word, inst_addr_o = head addr, inst_valid_o=1.
  - Else inst_o = inst_addr_o = BUBBLE, inst_valid_o=0.
- Overflow is impossible: a request is issued only when a FIFO slot is reserved for it.
- Adder is 32-bit and wraps modulo 2^32; 32'hFFFFFFFC+4 = 0.

## Timing
- Reset values:
  - fpc=RESET_PC, state IDLE, count 0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - inst_o=BUBBLE, inst_addr_o=BUBBLE, inst_valid_o=0.
- Reset asserted mid-request drops imem_req_o immediately. Memory shares rst_i, so no response is expected afterwards.
- First edge after reset release: IDLE→WAIT, so imem_req_o is high in cycle 1.
- An ack in cycle N pushes at edge N. inst_o shows the word in cycle N+1, and IF/ID captures it at edge N+1 if not stalled.
- With ack every cycle, throughput is 1 instruction/cycle after the first.
- Stall holds the FIFO head stable. Fetch continues until the FIFO is full, then imem_req_o drops.
- redirect_i takes effect at the edge it is sampled. Outputs show BUBBLE from the next cycle until the first new word.
- Minimum redirect-to-valid latency is 2 cycles: IDLE→WAIT, then ack.

## Test plan
- Reset, RESET_PC=0, memory acks every cycle with data=addr|0x1000 → requests 0,4,8,…; inst_addr_o sequence 4,8,12 with inst_o 0x1000,0x1004,0x1008; valid from cycle 2.
- stall_i high 4 cycles during streaming → inst_o frozen, imem_req_o low once count=2. After release, no address skipped or repeated.
- Ack latency 3 cycles → inst_o=inst_addr_o=0xFC000000, valid=0 between deliveries.
- redirect_i to 0x40 in WAIT with ack 2 cycles later → returned word dropped, next imem_addr_o=0x40, first valid inst_addr_o=0x44.
- redirect_i to 0x80 in the same cycle as ack, FIFO holding 1 entry → entry and word dropped, next request 0x80.
- rst_i pulsed while in WAIT at 0x20 → imem_req_o low immediately; after release the first request is RESET_PC.
